// File: rtl/cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_ocimem_ctrl
// Purpose  : System-clock debug-memory access engine. It takes the JTAG data
//            word (jdo) and the take_*_ocimem_* strobes from the sysclk stage,
//            performs the requested single-word read or write on a
//            waitrequest-style master port, and reports the result through
//            MonAReg/MonDReg/monitor_ready/monitor_error.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            jdo[37:0]                    - captured JTAG data
//            take_action_ocimem_a         - load address, optionally read
//            take_action_ocimem_b         - write jdo[34:3], then increment
//            take_no_action_ocimem_a      - read at MonAReg, then increment
//            mem_address/read/write/writedata, mem_readdata, mem_waitrequest
//                                         - debug memory master port
//            MonAReg, MonDReg             - address / data monitor registers
//            monitor_ready, monitor_error - command status
// Revision : 1.0 - initial release
// ============================================================================
module cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // The abort fires on the TIMEOUT-th stalled edge, i.e. when the count of
  // previously stalled edges equals TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   areg_q, areg_d;
  logic [31:0]         dreg_q, dreg_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                incr_q, incr_d;     // increment MonAReg on completion
  logic [15:0]         tcnt_q, tcnt_d;

  logic                any_strobe;
  logic [ADDR_W-1:0]   jdo_addr;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;
  assign jdo_addr   = jdo[17 +: ADDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      areg_q  <= '0;
      dreg_q  <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      incr_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      dreg_q  <= dreg_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      incr_q  <= incr_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    dreg_d  = dreg_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    error_d = error_q;
    incr_d  = incr_q;
    tcnt_d  = tcnt_q;

    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (take_action_ocimem_a) begin
          areg_d  = jdo_addr;
          error_d = 1'b0;
          if (jdo[35]) begin
            state_d = RD;
            maddr_d = jdo_addr;
            incr_d  = 1'b0;
            ready_d = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          state_d = WR;
          maddr_d = areg_q;
          wdata_d = jdo[34:3];
          dreg_d  = jdo[34:3];
          incr_d  = 1'b1;
          ready_d = 1'b0;
          error_d = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
          maddr_d = areg_q;
          incr_d  = 1'b1;
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end

      RD, WR: begin
        // A command arriving mid-access is dropped but flagged.
        if (any_strobe) begin
          error_d = 1'b1;
        end
        if (!mem_waitrequest) begin
          if (state_q == RD) begin
            dreg_d = mem_readdata;
          end
          if (incr_q) begin
            areg_d = areg_q + ADDR_W'(1);
          end
          state_d = IDLE;
          ready_d = 1'b1;
          tcnt_d  = '0;
        end else if (tcnt_q >= TO_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          error_d = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requests decode straight from the state so an async reset removes them
  // without waiting for a clock edge.
  assign mem_read      = (state_q == RD);
  assign mem_write     = (state_q == WR);
  assign mem_address   = maddr_q;
  assign mem_writedata = wdata_q;
  assign MonAReg       = areg_q;
  assign MonDReg       = dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_debug_ocimem_ctrl
// Purpose  : Directed self-checking bench for cpu_debug_ocimem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_debug_ocimem_ctrl;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks;
  int failures;

  cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_action_ocimem_a),
    .take_action_ocimem_b   (take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .mem_address            (mem_address),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_readdata           (mem_readdata),
    .mem_waitrequest        (mem_waitrequest),
    .MonAReg                (MonAReg),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] v;
    v        = '0;
    v[35]    = rd;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v;
    v       = '0;
    v[34:3] = d;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    jdo      = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_readdata    = '0;
    mem_waitrequest = 1'b0;

    // ---- reset values ----
    tick(); tick();
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_req",   {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_areg",  32'(MonAReg), 32'd0);
    chk("rst_dreg",  MonDReg, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---- address load with auto-read, no stall ----
    mem_readdata = 32'hCAFEF00D;
    jdo = jdo_a(1'b1, 8'h10);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("t1_read_hi", 32'(mem_read), 32'd1);
    chk("t1_addr",    32'(mem_address), 32'h10);
    chk("t1_busy",    32'(monitor_ready), 32'd0);
    tick();
    chk("t1_read_lo", 32'(mem_read), 32'd0);
    chk("t1_dreg",    MonDReg, 32'hCAFEF00D);
    chk("t1_areg",    32'(MonAReg), 32'h10);
    chk("t1_ready",   32'(monitor_ready), 32'd1);

    // ---- load 0xFF without read, write there, wrap, then read-increment ----
    jdo = jdo_a(1'b0, 8'hFF);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("t2_load_areg",  32'(MonAReg), 32'hFF);
    chk("t2_load_ready", 32'(monitor_ready), 32'd1);
    chk("t2_load_noreq", {30'd0, mem_read, mem_write}, 32'd0);
    chk("t2_load_dreg",  MonDReg, 32'hCAFEF00D);
    jdo = jdo_b(32'h12345678);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("t2_wr_hi",   32'(mem_write), 32'd1);
    chk("t2_wr_addr", 32'(mem_address), 32'hFF);
    chk("t2_wr_data", mem_writedata, 32'h12345678);
    chk("t2_wr_dreg", MonDReg, 32'h12345678);
    tick();
    chk("t2_wr_lo",   32'(mem_write), 32'd0);
    chk("t2_wrap",    32'(MonAReg), 32'h00);
    mem_readdata = 32'hA5A50001;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("t2_rd_hi",   32'(mem_read), 32'd1);
    chk("t2_rd_addr", 32'(mem_address), 32'h00);
    tick();
    chk("t2_rd_areg", 32'(MonAReg), 32'h01);
    chk("t2_rd_dreg", MonDReg, 32'hA5A50001);

    // ---- 5-cycle stall on a read ----
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'h11111111;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_hold%0d", i), {23'd0, mem_read, mem_address}, {23'd0, 1'b1, 8'h01});
    end
    chk("t3_dreg_hold", MonDReg, 32'hA5A50001);
    mem_waitrequest = 1'b0;
    mem_readdata    = 32'h600DBEEF;
    tick();
    chk("t3_read_lo", 32'(mem_read), 32'd0);
    chk("t3_dreg",    MonDReg, 32'h600DBEEF);
    chk("t3_areg",    32'(MonAReg), 32'h02);
    chk("t3_status",  {30'd0, monitor_ready, monitor_error}, 32'b10);

    // ---- waitrequest stuck high: timeout after 255 stalled cycles ----
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'h0BADF00D;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    repeat (254) tick();
    chk("t4_still_hi", 32'(mem_read), 32'd1);
    tick();
    chk("t4_dropped", 32'(mem_read), 32'd0);
    chk("t4_status",  {30'd0, monitor_ready, monitor_error}, 32'b11);
    chk("t4_areg",    32'(MonAReg), 32'h02);
    chk("t4_dreg",    MonDReg, 32'h600DBEEF);
    mem_waitrequest = 1'b0;
    jdo = jdo_a(1'b0, 8'h20);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("t4_err_clr", {30'd0, monitor_ready, monitor_error}, 32'b10);
    chk("t4_areg2",   32'(MonAReg), 32'h20);

    // ---- strobe while a write is in flight ----
    mem_waitrequest = 1'b1;
    jdo = jdo_b(32'hDEADBEEF);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("t5_wr_held", {23'd0, mem_write, mem_address}, {23'd0, 1'b1, 8'h20});
    chk("t5_no_read", 32'(mem_read), 32'd0);
    chk("t5_err",     32'(monitor_error), 32'd1);
    mem_waitrequest = 1'b0;
    tick();
    chk("t5_wr_lo",   32'(mem_write), 32'd0);
    chk("t5_areg",    32'(MonAReg), 32'h21);
    chk("t5_status",  {30'd0, monitor_ready, monitor_error}, 32'b11);
    chk("t5_dreg",    MonDReg, 32'hDEADBEEF);

    // ---- simultaneous ocimem_a and ocimem_b in IDLE ----
    jdo = jdo_a(1'b0, 8'h40);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    chk("t6_noreq", {30'd0, mem_read, mem_write}, 32'd0);
    chk("t6_areg",  32'(MonAReg), 32'h40);
    chk("t6_dreg",  MonDReg, 32'hDEADBEEF);
    chk("t6_status", {30'd0, monitor_ready, monitor_error}, 32'b10);
    tick();
    chk("t6_still_idle", {30'd0, mem_read, mem_write}, 32'd0);

    // ---- reset pulsed mid-write ----
    mem_waitrequest = 1'b1;
    jdo = jdo_b(32'h87654321);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("t7_wr_hi", 32'(mem_write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_wr_async", 32'(mem_write), 32'd0);
    chk("t7_addr",     32'(mem_address), 32'd0);
    chk("t7_wdata",    mem_writedata, 32'd0);
    chk("t7_areg",     32'(MonAReg), 32'd0);
    chk("t7_dreg",     MonDReg, 32'd0);
    chk("t7_status",   {30'd0, monitor_ready, monitor_error}, 32'b10);
    tick();
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    tick();
    chk("t7_post", {30'd0, mem_read, mem_write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
